eth_mac_tx_rr_arbiter: RTL
==========================

ETH_MAC_TX_RR_ARBITER -- requirements
Module: eth_mac_tx_rr_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of frame sources; legal range 2..8, out-of-range is a $fatal at elaboration.
REQ-002 Parameter IFG_HOLD_CYCLES, default 12, idle cycles enforced between frames.
REQ-003 Parameter DONE_TIMEOUT_CYCLES, default 4096, maximum wait for MAC completion after EOF.
REQ-004 Ports: i_txmac_clk in 1, sole clock; i_txmac_clk_arst in 1, reset, asynchronous, active-high.
REQ-005 Ports: i_src_avail in NUM_SRC, full frame ready per source; i_src_byte_vld in NUM_SRC; i_src_eof in NUM_SRC; i_src_byte in NUM_SRC x 8; o_src_byte_rd out NUM_SRC, per-source read strobe.
REQ-006 Ports: o_tx_fifoavail out 1; o_tx_fifoempty out 1; o_tx_fifoeof out 1; o_tx_fifodata out 8; i_tx_macread in 1; i_tx_done in 1; i_tx_discfrm in 1 (Lattice GBIT MAC Tx side).
REQ-007 Ports: o_grant_idx out 3, current/last granted source; o_frames_sent out 32; o_done_timeouts out 16; o_busy out 1.

Function
REQ-008 FSM states SHALL be IDLE, ARB, XFER, WAIT_DONE, GAP.
REQ-009 IDLE: if any i_src_avail bit set, go to ARB next cycle; else stay.
REQ-010 ARB: grant the first requesting index searching from (last_grant+1) mod NUM_SRC upward with wrap; register it into o_grant_idx; go to XFER; exactly one cycle.
REQ-011 If the request drops before ARB samples it, ARB SHALL return to IDLE without changing o_grant_idx.
REQ-012 XFER: o_tx_fifoavail=1; o_tx_fifoempty = ~i_src_byte_vld[grant].
REQ-013 o_src_byte_rd[grant] = i_tx_macread & i_src_byte_vld[grant] & ~eof_taken; all other o_src_byte_rd bits 0 in every state.
REQ-014 Read latency one cycle: o_tx_fifodata and o_tx_fifoeof SHALL be registered from the granted source on the cycle a read strobe is issued and held until the next strobe.
REQ-015 o_tx_fifoeof SHALL be a single-cycle pulse on the cycle after the EOF byte is strobed.
REQ-016 On the strobe of a byte with i_src_eof[grant]=1: set eof_taken, deassert o_tx_fifoavail next cycle, go to WAIT_DONE; further macread ignored.
REQ-017 i_tx_macread while granted source byte_vld=0 SHALL issue no strobe and hold data (underrun stall).
REQ-018 WAIT_DONE: on i_tx_done or i_tx_discfrm go to GAP; o_frames_sent increments (wraps at 2^32) only on i_tx_done.
REQ-019 WAIT_DONE timeout: counter reaching DONE_TIMEOUT_CYCLES-1 SHALL go to GAP and increment o_done_timeouts (saturates at 0xFFFF).
REQ-020 Simultaneous done and timeout-expiry in the same cycle SHALL count as done only.
REQ-021 GAP: hold IFG_HOLD_CYCLES cycles, then IDLE; i_src_avail ignored during GAP.
REQ-022 o_busy = 1 in every state except IDLE.
REQ-023 i_tx_done/i_tx_discfrm outside WAIT_DONE SHALL be ignored.

Reset
REQ-024 Asserting i_txmac_clk_arst at any time, including mid-XFER, SHALL immediately force IDLE, all o_src_byte_rd=0, o_tx_fifoavail=0, o_tx_fifoempty=1, o_tx_fifoeof=0, o_tx_fifodata=0, o_grant_idx=NUM_SRC-1 (so first grant searches from 0), counters 0, eof_taken=0.
REQ-025 Reset deassertion SHALL be synchronised externally; no strobe issued in the first cycle after release.

Structure
REQ-026 FSM state enum and ETH_IFG_BYTES constant SHALL live in ethernet_support_pkg.
REQ-027 Round-robin search SHALL be one combinational sub-module eth_rr_picker (inputs req vector, last grant; outputs grant index, any_req).

Verification
REQ-028 Reset, src1 avail with 64-byte frame, macread held high -> grant 1 at ARB+1, 64 strobes on o_src_byte_rd[1], data lags strobe by 1 cycle, one o_tx_fifoeof pulse, o_tx_fifoavail low after EOF.
REQ-029 All 4 sources avail continuously, i_tx_done after each EOF -> grant order 0,1,2,3,0; o_frames_sent=5; >=12 idle cycles between fifoavail windows.
REQ-030 Source 2 byte_vld dropped for 5 cycles mid-frame -> o_tx_fifoempty=1 for those cycles, no strobes, no data change, frame completes intact.
REQ-031 No i_tx_done after EOF -> GAP entered after exactly 4096 WAIT_DONE cycles, o_done_timeouts=1, o_frames_sent unchanged; i_tx_discfrm instead -> GAP, both counters unchanged.
REQ-032 Async reset asserted mid-XFER between clock edges -> outputs at reset values before next edge; after release src0 frame served normally.
REQ-033 i_tx_done pulsed in IDLE and XFER -> no counter change, no state change.

Source files
------------

// File: rtl/ethernet_support_pkg.sv
// Shared Ethernet Tx definitions: arbiter FSM states and the standard inter-frame gap length.
package ethernet_support_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        XFER,
        WAIT_DONE,
        GAP
    } txArbState_e;

    localparam int ETH_IFG_BYTES = 12;

endpackage

// File: rtl/eth_rr_picker.sv
// Combinational round-robin search: first requester strictly after lastGrant_i, wrapping modulo NUM_SRC.
module eth_rr_picker #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [2:0]         lastGrant_i,
    output logic [2:0]         grant_o,
    output logic               anyReq_o
);

    // Walk offsets from farthest to nearest so the nearest requester is the last one written.
    always_comb begin
        grant_o  = lastGrant_i;
        anyReq_o = 1'b0;
        for (int offs = NUM_SRC; offs >= 1; offs--) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (req_i[j] && (j == ((int'(lastGrant_i) + offs) % NUM_SRC))) begin
                    grant_o  = 3'(j);
                    anyReq_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eth_mac_tx_rr_arbiter.sv
// Round-robin arbiter feeding whole frames from NUM_SRC byte sources into the Lattice GBIT MAC Tx FIFO port.
module eth_mac_tx_rr_arbiter
    import ethernet_support_pkg::*;
#(
    parameter int NUM_SRC             = 4,
    parameter int IFG_HOLD_CYCLES     = ETH_IFG_BYTES,
    parameter int DONE_TIMEOUT_CYCLES = 4096
) (
    input  logic                    i_txmac_clk,
    input  logic                    i_txmac_clk_arst,
    input  logic [NUM_SRC-1:0]      i_src_avail,
    input  logic [NUM_SRC-1:0]      i_src_byte_vld,
    input  logic [NUM_SRC-1:0]      i_src_eof,
    input  logic [NUM_SRC-1:0][7:0] i_src_byte,
    output logic [NUM_SRC-1:0]      o_src_byte_rd,
    output logic                    o_tx_fifoavail,
    output logic                    o_tx_fifoempty,
    output logic                    o_tx_fifoeof,
    output logic [7:0]              o_tx_fifodata,
    input  logic                    i_tx_macread,
    input  logic                    i_tx_done,
    input  logic                    i_tx_discfrm,
    output logic [2:0]              o_grant_idx,
    output logic [31:0]             o_frames_sent,
    output logic [15:0]             o_done_timeouts,
    output logic                    o_busy
);

    localparam int WAIT_W = (DONE_TIMEOUT_CYCLES > 1) ? $clog2(DONE_TIMEOUT_CYCLES) : 1;
    localparam int GAP_W  = (IFG_HOLD_CYCLES > 1) ? $clog2(IFG_HOLD_CYCLES) : 1;

    if (NUM_SRC < 2 || NUM_SRC > 8) begin : gNumSrcCheck
        $fatal(1, "eth_mac_tx_rr_arbiter: NUM_SRC=%0d outside 2..8", NUM_SRC);
    end
    if (IFG_HOLD_CYCLES < 1 || DONE_TIMEOUT_CYCLES < 1) begin : gCycleCheck
        $fatal(1, "eth_mac_tx_rr_arbiter: IFG/timeout cycle counts must be at least 1");
    end

    txArbState_e       state_q;
    logic [2:0]        grantIdx_q;
    logic              eofTaken_q;
    logic [7:0]        fifoData_q;
    logic              fifoEof_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [GAP_W-1:0]  gapCnt_q;
    logic [31:0]       framesSent_q;
    logic [15:0]       doneTimeouts_q;

    logic [2:0] pickIdx;
    logic       pickAny;
    logic       selVld;
    logic       selEof;
    logic [7:0] selByte;
    logic       readStrobe;
    logic       waitExpired;

    eth_rr_picker #(
        .NUM_SRC(NUM_SRC)
    ) uPicker (
        .req_i      (i_src_avail),
        .lastGrant_i(grantIdx_q),
        .grant_o    (pickIdx),
        .anyReq_o   (pickAny)
    );

    always_comb begin
        selVld  = 1'b0;
        selEof  = 1'b0;
        selByte = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grantIdx_q == 3'(i)) begin
                selVld  = i_src_byte_vld[i];
                selEof  = i_src_eof[i];
                selByte = i_src_byte[i];
            end
        end
    end

    // An empty granted source stalls the MAC: no strobe goes out and the last byte stays on the bus.
    assign readStrobe  = (state_q == XFER) && i_tx_macread && selVld && !eofTaken_q;
    assign waitExpired = (waitCnt_q == WAIT_W'(DONE_TIMEOUT_CYCLES - 1));

    always_comb begin
        o_src_byte_rd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            o_src_byte_rd[i] = readStrobe && (grantIdx_q == 3'(i));
        end
    end

    assign o_tx_fifoavail  = (state_q == XFER) && !eofTaken_q;
    assign o_tx_fifoempty  = (state_q == XFER) ? !selVld : 1'b1;
    assign o_tx_fifoeof    = fifoEof_q;
    assign o_tx_fifodata   = fifoData_q;
    assign o_grant_idx     = grantIdx_q;
    assign o_frames_sent   = framesSent_q;
    assign o_done_timeouts = doneTimeouts_q;
    assign o_busy          = (state_q != IDLE);

    always_ff @(posedge i_txmac_clk or posedge i_txmac_clk_arst) begin
        if (i_txmac_clk_arst) begin
            state_q        <= IDLE;
            grantIdx_q     <= 3'(NUM_SRC - 1);
            eofTaken_q     <= 1'b0;
            fifoData_q     <= 8'h00;
            fifoEof_q      <= 1'b0;
            waitCnt_q      <= '0;
            gapCnt_q       <= '0;
            framesSent_q   <= 32'd0;
            doneTimeouts_q <= 16'd0;
        end else begin
            fifoEof_q <= readStrobe && selEof;
            if (readStrobe) begin
                fifoData_q <= selByte;
            end

            case (state_q)
                IDLE: begin
                    if (|i_src_avail) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    if (pickAny) begin
                        grantIdx_q <= pickIdx;
                        eofTaken_q <= 1'b0;
                        state_q    <= XFER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if (readStrobe && selEof) begin
                        eofTaken_q <= 1'b1;
                        waitCnt_q  <= '0;
                        state_q    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Done is checked first so a completion in the expiry cycle is not counted as a timeout.
                    gapCnt_q <= '0;
                    if (i_tx_done) begin
                        framesSent_q <= framesSent_q + 32'd1;
                        state_q      <= GAP;
                    end else if (i_tx_discfrm) begin
                        state_q <= GAP;
                    end else if (waitExpired) begin
                        if (doneTimeouts_q != 16'hFFFF) begin
                            doneTimeouts_q <= doneTimeouts_q + 16'd1;
                        end
                        state_q <= GAP;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gapCnt_q == GAP_W'(IFG_HOLD_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
